// File: rtl/ecc_mem_port_arbiter.sv
// Shares one memory command port between a FIFO write side and read side, with bounded-burst alternation.
// Define ARB_ECC_ERR_EN to add mem_rd_err / rd_err / ecc_err_sticky uncorrectable-error reporting.
module ecc_mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef ARB_ECC_ERR_EN
  input  logic                  mem_rd_err,
  output logic                  rd_err,
  output logic                  ecc_err_sticky,
`endif
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0]  MAX_B   = BURST_W'(MAX_BURST);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [BURST_W-1:0]    burst_q, burst_d, burst_inc;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  mem_en_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic                  we_ok, re_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign we_ok = wr_req & ~full;
  assign re_ok = rd_req & ~empty;

  // With both sides eligible, stay on the current side until it has used MAX_BURST grants.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (we_ok && re_ok) begin
      case (state_q)
        S_WR: if (burst_q < MAX_B) wr_gnt = 1'b1; else rd_gnt = 1'b1;
        S_RD: if (burst_q < MAX_B) rd_gnt = 1'b1; else wr_gnt = 1'b1;
        default: wr_gnt = 1'b1;
      endcase
    end else begin
      wr_gnt = we_ok;
      rd_gnt = re_ok;
    end
  end

  assign burst_inc = (burst_q == MAX_B) ? MAX_B : burst_q + BURST_W'(1);

  always_comb begin
    state_d = S_IDLE;
    burst_d = '0;
    if (wr_gnt) begin
      state_d = S_WR;
      burst_d = (state_q == S_WR) ? burst_inc : BURST_W'(1);
    end else if (rd_gnt) begin
      state_d = S_RD;
      burst_d = (state_q == S_RD) ? burst_inc : BURST_W'(1);
    end
  end

  always_comb begin
    case ({wr_gnt, rd_gnt})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Read-return tracker: one bit per cycle of memory latency, fed by issued read commands.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = mem_en_q & ~mem_we_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      burst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vld_q       <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      mem_en_q <= wr_gnt | rd_gnt;
      mem_we_q <= wr_gnt;
      if (wr_gnt) begin
        wr_ptr_q    <= wr_ptr_q + ADDR_WIDTH'(1);
        mem_addr_q  <= wr_ptr_q;
        mem_wdata_q <= wr_data;
      end
      if (rd_gnt) begin
        rd_ptr_q   <= rd_ptr_q + ADDR_WIDTH'(1);
        mem_addr_q <= rd_ptr_q;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign rd_valid  = vld_q[RD_LATENCY-1];
  assign rd_data   = rd_valid ? mem_rdata : '0;

`ifdef ARB_ECC_ERR_EN
  logic sticky_q;

  assign rd_err = rd_valid & mem_rd_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      sticky_q <= 1'b0;
    else if (rd_err) sticky_q <= 1'b1;
  end

  assign ecc_err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_ecc_mem_port_arbiter.sv
// Self-checking bench for ecc_mem_port_arbiter: FIFO-level reference model plus a behavioural memory.
// Covers the ARB_ECC_ERR_EN ports when that macro is defined.
module tb_ecc_mem_port_arbiter;
  localparam int DW = 32, AW = 10, RL = 2, MB = 4, DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic wr_gnt, rd_gnt, rd_valid, mem_en, mem_we, full, empty;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0] count;
`ifdef ARB_ECC_ERR_EN
  logic mem_rd_err, rd_err, ecc_err_sticky;
`endif

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  ecc_mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef ARB_ECC_ERR_EN
    .mem_rd_err(mem_rd_err), .rd_err(rd_err), .ecc_err_sticky(ecc_err_sticky),
`endif
    .count(count), .full(full), .empty(empty));

  // Behavioural memory with fixed read latency
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rpipe [RL];
  assign mem_rdata = rpipe[RL-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : $urandom;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end

`ifdef ARB_ECC_ERR_EN
  logic epipe [RL];
  int rd_issue_cnt = 0;
  int err_target = -1;
  assign mem_rd_err = epipe[RL-1];

  always @(posedge clk) begin
    epipe[0] <= mem_en && !mem_we && (rd_issue_cnt == err_target);
    for (int i = 1; i < RL; i++) epipe[i] <= epipe[i-1];
    if (mem_en && !mem_we) rd_issue_cnt <= rd_issue_cnt + 1;
  end
`endif

  // Reference model: FIFO contents, pointers, grant history, pending read returns
  logic [DW-1:0] m_q [$];
  int m_wptr, m_rptr, m_last, m_run, cyc;
  bit m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int due_q [$];
  logic [DW-1:0] dat_q [$];
  bit exp_wg, exp_rg, exp_vld;
  logic [DW-1:0] exp_rdata;
  int exp_count;

  function automatic void model_reset();
    m_q.delete(); due_q.delete(); dat_q.delete();
    m_wptr = 0; m_rptr = 0; m_last = 0; m_run = 0;
    m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
  endfunction

  function automatic void predict();
    bit weok = wr_req && (m_q.size() < DEPTH);
    bit reok = rd_req && (m_q.size() > 0);
    exp_wg = 0; exp_rg = 0;
    if (weok && reok) begin
      if (m_last == 0) exp_wg = 1;
      else if (m_run < MB) begin if (m_last == 1) exp_wg = 1; else exp_rg = 1; end
      else begin if (m_last == 1) exp_rg = 1; else exp_wg = 1; end
    end else if (weok) exp_wg = 1;
    else if (reok) exp_rg = 1;
    exp_count = m_q.size();
    exp_vld = (due_q.size() > 0) && (due_q[0] == cyc);
    exp_rdata = exp_vld ? dat_q[0] : '0;
  endfunction

  function automatic void commit();
    int side = 0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    m_en = exp_wg || exp_rg;
    m_we = exp_wg;
    if (exp_wg) begin
      m_addr = AW'(m_wptr); m_wdata = wr_data; m_q.push_back(wr_data);
      m_wptr = (m_wptr + 1) % DEPTH; side = 1;
    end
    if (exp_rg) begin
      m_addr = AW'(m_rptr); due_q.push_back(cyc + RL + 1); dat_q.push_back(m_q.pop_front());
      m_rptr = (m_rptr + 1) % DEPTH; side = 2;
    end
    if (side == 0) begin m_last = 0; m_run = 0; end
    else if (side == m_last) m_run = (m_run < MB) ? m_run + 1 : MB;
    else begin m_last = side; m_run = 1; end
    cyc++;
  endfunction

  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
    wr_req = w; rd_req = r; wr_data = d;
    predict();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_req = 0; rd_req = 0; model_reset(); cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_en !== 0 || rd_valid !== 0 || full !== 0 || empty !== 1 || count !== 0 || mem_addr !== 0 || mem_wdata !== 0)
      begin errors++; $display("FAIL in_reset en=%b vld=%b full=%b empty=%b count=%0d addr=%0d wdata=%h want 0 0 0 1 0 0 0",
                               mem_en, rd_valid, full, empty, count, mem_addr, mem_wdata); end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, '0);
      checks++;
      if (mem_en !== 0 || count !== 0 || empty !== 1 || full !== 0 || rd_valid !== 0 || wr_gnt !== 0 || rd_gnt !== 0)
        begin errors++; $display("FAIL idle_after_reset cyc=%0d en=%b count=%0d empty=%b full=%b vld=%b want 0 0 1 0 0",
                                 k, mem_en, count, empty, full, rd_valid); end
      advance();
    end
  endtask

  task automatic test_fifo_order();
    int gc [$]; int vc [$]; logic [DW-1:0] vd [$];
    for (int k = 0; k < 5 + 5 + RL + 3; k++) begin
      if (k < 5) drive(1, 0, 32'hA0 + k);
      else if (k < 10) drive(0, 1, '0);
      else drive(0, 0, '0);
      checks++;
      if (wr_gnt !== exp_wg || rd_gnt !== exp_rg)
        begin errors++; $display("FAIL order_grant k=%0d got w%b r%b want w%b r%b", k, wr_gnt, rd_gnt, exp_wg, exp_rg); end
      checks++;
      if (mem_en !== m_en || (m_en && (mem_we !== m_we || mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata))))
        begin errors++; $display("FAIL order_mem k=%0d got en%b we%b a%0d d%h want en%b we%b a%0d d%h",
                                 k, mem_en, mem_we, mem_addr, mem_wdata, m_en, m_we, m_addr, m_wdata); end
      checks++;
      if (count !== exp_count)
        begin errors++; $display("FAIL order_count k=%0d got %0d want %0d", k, count, exp_count); end
      if (rd_gnt === 1'b1) gc.push_back(k);
      if (rd_valid === 1'b1) begin vc.push_back(k); vd.push_back(rd_data); end
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= vc.size() || i >= gc.size() || vc[i] - gc[i] != RL + 1 || vd[i] !== 32'hA0 + i)
        begin errors++; $display("FAIL order_return idx=%0d got data=%h lat=%0d want data=%h lat=%0d",
                                 i, (i < vd.size()) ? vd[i] : '0, (i < vc.size() && i < gc.size()) ? vc[i] - gc[i] : -1,
                                 32'hA0 + i, RL + 1); end
    end
  endtask

  task automatic test_burst();
    for (int k = 0; k < 8 + 3; k++) begin
      drive(k < 8, 0, $urandom);
      checks++;
      if (wr_gnt !== exp_wg || rd_gnt !== 0)
        begin errors++; $display("FAIL burst_fill k=%0d got w%b r%b want w%b r0", k, wr_gnt, rd_gnt, exp_wg); end
      advance();
    end
    for (int k = 0; k < 16; k++) begin
      bit want_w = ((k / 4) % 2) == 0;
      drive(1, 1, $urandom);
      checks++;
      if (wr_gnt !== want_w || rd_gnt !== !want_w)
        begin errors++; $display("FAIL burst_pattern k=%0d got w%b r%b want w%b r%b", k, wr_gnt, rd_gnt, want_w, !want_w); end
      checks++;
      if (mem_en !== m_en || (m_en && (mem_we !== m_we || mem_addr !== m_addr)) || rd_valid !== exp_vld || (exp_vld && rd_data !== exp_rdata))
        begin errors++; $display("FAIL burst_mem k=%0d got en%b we%b a%0d vld%b d%h want en%b we%b a%0d vld%b d%h",
                                 k, mem_en, mem_we, mem_addr, rd_valid, rd_data, m_en, m_we, m_addr, exp_vld, exp_rdata); end
      advance();
    end
    for (int k = 0; k < RL + 2; k++) begin
      drive(0, 0, '0);
      checks++;
      if (rd_valid !== exp_vld || (exp_vld && rd_data !== exp_rdata))
        begin errors++; $display("FAIL burst_tail k=%0d got vld%b d%h want vld%b d%h", k, rd_valid, rd_data, exp_vld, exp_rdata); end
      advance();
    end
    drive(0, 0, '0);
    checks++;
    if (count !== 8) begin errors++; $display("FAIL burst_count got %0d want 8", count); end
    advance();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600 + RL + 2; k++) begin
      int pw = (k < 200) ? 70 : (k < 400) ? 40 : 90;
      int pr = (k < 200) ? 40 : (k < 400) ? 70 : 90;
      if (k < 600) drive($urandom_range(99) < pw, $urandom_range(99) < pr, $urandom);
      else drive(0, 0, '0);
      checks++;
      if (wr_gnt !== exp_wg || rd_gnt !== exp_rg)
        begin errors++; $display("FAIL rand_grant k=%0d got w%b r%b want w%b r%b", k, wr_gnt, rd_gnt, exp_wg, exp_rg); end
      checks++;
      if (mem_en !== m_en || (m_en && (mem_we !== m_we || mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata))))
        begin errors++; $display("FAIL rand_mem k=%0d got en%b we%b a%0d d%h want en%b we%b a%0d d%h",
                                 k, mem_en, mem_we, mem_addr, mem_wdata, m_en, m_we, m_addr, m_wdata); end
      checks++;
      if (rd_valid !== exp_vld || (exp_vld && rd_data !== exp_rdata))
        begin errors++; $display("FAIL rand_return k=%0d got vld%b d%h want vld%b d%h", k, rd_valid, rd_data, exp_vld, exp_rdata); end
      checks++;
      if (count !== exp_count || full !== (exp_count == DEPTH) || empty !== (exp_count == 0))
        begin errors++; $display("FAIL rand_count k=%0d got %0d f%b e%b want %0d", k, count, full, empty, exp_count); end
      advance();
    end
  endtask

  task automatic test_full_wrap();
    int prev_ra = -1; bit seen_wrap = 0;
    reset = 1'b0; model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < DEPTH + 3 + 2 + DEPTH + 4 + RL + 2; k++) begin
      if (k < DEPTH + 3) drive(1, 0, $urandom);
      else if (k == DEPTH + 3) drive(0, 1, '0);
      else if (k == DEPTH + 4) drive(1, 0, 32'h5A5A0000);
      else if (m_q.size() > 0) drive(0, 1, '0);
      else drive(0, 0, '0);
      checks++;
      if (wr_gnt !== exp_wg || rd_gnt !== exp_rg)
        begin errors++; $display("FAIL full_grant k=%0d got w%b r%b want w%b r%b", k, wr_gnt, rd_gnt, exp_wg, exp_rg); end
      checks++;
      if (mem_en !== m_en || (m_en && (mem_we !== m_we || mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata))))
        begin errors++; $display("FAIL full_mem k=%0d got en%b we%b a%0d want en%b we%b a%0d", k, mem_en, mem_we, mem_addr, m_en, m_we, m_addr); end
      checks++;
      if (rd_valid !== exp_vld || (exp_vld && rd_data !== exp_rdata) || count !== exp_count || full !== (exp_count == DEPTH) || empty !== (exp_count == 0))
        begin errors++; $display("FAIL full_state k=%0d got vld%b d%h cnt%0d f%b e%b want vld%b d%h cnt%0d",
                                 k, rd_valid, rd_data, count, full, empty, exp_vld, exp_rdata, exp_count); end
      if (k >= DEPTH && k < DEPTH + 3) begin
        checks++;
        if (full !== 1 || wr_gnt !== 0) begin errors++; $display("FAIL full_stall k=%0d got full%b wgnt%b want full1 wgnt0", k, full, wr_gnt); end
      end
      if (k == DEPTH + 5) begin
        checks++;
        if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 0)
          begin errors++; $display("FAIL full_wrap_write got en%b we%b a%0d want en1 we1 a0", mem_en, mem_we, mem_addr); end
      end
      if (mem_en === 1'b1 && mem_we === 1'b0) begin
        if (mem_addr === '0 && prev_ra == DEPTH - 1) seen_wrap = 1;
        prev_ra = int'(mem_addr);
      end
      advance();
    end
    checks++;
    if (seen_wrap !== 1) begin errors++; $display("FAIL rd_ptr_wrap got %b want 1", seen_wrap); end
  endtask

  task automatic test_reset_midflight();
    drive(1, 0, 32'h11); advance();
    drive(1, 0, 32'h22); advance();
    drive(0, 1, '0);
    checks++;
    if (rd_gnt !== 1) begin errors++; $display("FAIL mid_rd_gnt got %b want 1", rd_gnt); end
    advance();
    checks++;
    if (mem_en !== 1 || mem_we !== 0) begin errors++; $display("FAIL mid_rd_issue got en%b we%b want en1 we0", mem_en, mem_we); end
    reset = 1'b0; model_reset();
    #1;
    checks++;
    if (mem_en !== 0 || count !== 0 || empty !== 1 || rd_valid !== 0)
      begin errors++; $display("FAIL mid_in_reset got en%b cnt%0d e%b vld%b want 0 0 1 0", mem_en, count, empty, rd_valid); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, '0);
      checks++;
      if (rd_valid !== 0 || count !== 0 || empty !== 1 || mem_en !== 0)
        begin errors++; $display("FAIL mid_after k=%0d got vld%b cnt%0d e%b en%b want 0 0 1 0", k, rd_valid, count, empty, mem_en); end
      advance();
    end
  endtask

`ifdef ARB_ECC_ERR_EN
  task automatic test_ecc();
    int vidx = 0; bit seen = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'hE0 + i);
      checks++;
      if (wr_gnt !== 1) begin errors++; $display("FAIL ecc_wr_gnt i=%0d got %b want 1", i, wr_gnt); end
      advance();
    end
    err_target = rd_issue_cnt + 2;
    for (int k = 0; k < 4 + RL + 3; k++) begin
      drive(0, k < 4, '0);
      checks++;
      if (rd_valid !== exp_vld || rd_err !== (exp_vld && vidx == 2) || (exp_vld && rd_data !== exp_rdata))
        begin errors++; $display("FAIL ecc_rd_err k=%0d got vld%b err%b d%h want vld%b err%b d%h",
                                 k, rd_valid, rd_err, rd_data, exp_vld, exp_vld && vidx == 2, exp_rdata); end
      checks++;
      if (ecc_err_sticky !== seen) begin errors++; $display("FAIL ecc_sticky k=%0d got %b want %b", k, ecc_err_sticky, seen); end
      if (exp_vld) begin if (vidx == 2) seen = 1; vidx++; end
      advance();
    end
    checks++;
    if (vidx != 4) begin errors++; $display("FAIL ecc_returns got %0d want 4", vidx); end
    reset = 1'b0; model_reset();
    #1;
    checks++;
    if (ecc_err_sticky !== 0) begin errors++; $display("FAIL ecc_sticky_reset got %b want 0", ecc_err_sticky); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_fifo_order();
    test_burst();
    test_random();
    test_full_wrap();
    test_reset_midflight();
`ifdef ARB_ECC_ERR_EN
    test_ecc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
